graphic_instruction_queue: RTL and testbench
============================================

Name: graphic_instruction_queue

Overview:
- Producer side of the sprite-instruction interface: buffers 32-bit draw instructions written by the ARMv4 core and presents them one at a time on INS to the graphic control unit.
- Advances to the next instruction when the graphic control unit pulses INS_DONE, meaning the 32x32 sprite is complete or the instruction was invisible.
- When no instruction is pending, drives an invisible idle instruction, so the graphic control unit never renders stale data.

Parameters:
- DEPTH, 8, number of queued instructions; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- HF_CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- WE  input  1  CPU write strobe; one instruction enqueued per cycle when high.
- WD  input  32  instruction word: [31:22] column, [21:13] row, [12:10] sprite select (3'b111 = invisible), [9:0] unused.
- INS_DONE  input  1  single-cycle pulse from the graphic control unit: current instruction consumed.
- CLR_OVF  input  1  clears the sticky OVERFLOW flag.
- INS  output  32  current instruction to the graphic control unit (registered).
- EMPTY  output  1  no instruction queued.
- FULL  output  1  COUNT == DEPTH.
- COUNT  output  AW+1  number of queued instructions, including the one currently on INS.
- OVERFLOW  output  1  sticky: a write was dropped.

Behaviour:
- Storage: circular buffer of DEPTH x 32, with write pointer WP and read pointer RP (AW bits each, wrap modulo DEPTH) and COUNT register.
- Reset (async, RST=1): WP=0, RP=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, INS=IDLE_INS (32'h0000_1C00, bits [12:10]=3'b111, all other bits 0). The storage array is not cleared.
- Reset asserted mid-operation discards all queued instructions. INS returns to IDLE_INS immediately (asynchronously).
- Push: when WE=1 and (COUNT<DEPTH or pop occurs in the same cycle), write WD at WP and increment WP.
- Pop: when INS_DONE=1 and COUNT>0, increment RP.
- INS_DONE while COUNT=0 is ignored: no pointer change, INS stays IDLE_INS.
- COUNT update per edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- INS register, loaded each edge from the post-update state:
  - mem[RP_next] if COUNT_next>0, else IDLE_INS.
  - If COUNT was 0 and a push occurs, INS takes WD directly (bypass). INS equals WD one cycle after the WE edge; latency is 1 cycle.
  - If COUNT_next>0 and the pushed entry lands at RP_next, INS also takes WD (bypass).
- Pop latency: INS shows the next queued instruction in the cycle after INS_DONE. It shows IDLE_INS if the queue drained.
- Full: WE with COUNT=DEPTH and no pop drops WD. WP and COUNT are unchanged and OVERFLOW is set on that edge.
- Full with simultaneous pop: the write is accepted and OVERFLOW is not set.
- OVERFLOW remains 1 until CLR_OVF=1 or reset. If CLR_OVF and a dropping write occur in the same cycle, set wins (OVERFLOW=1).
- Invisible instructions written by the CPU ([12:10]=3'b111) are queued like any other. The graphic control unit completes them in one cycle.
- Wrap-around: WP and RP roll from DEPTH-1 to 0 with no gap. COUNT, not pointer equality, determines full and empty.
- EMPTY = (COUNT==0) and FULL = (COUNT==DEPTH), both derived combinationally from the COUNT register.
- No combinational path from WE or WD to INS; INS is driven only by flops.

Test Plan:
- Reset/idle: assert RST mid-sim with 3 entries queued -> INS=32'h0000_1C00, COUNT=0, EMPTY=1, OVERFLOW=0 immediately. INS_DONE pulses afterward cause no change.
- Single instruction: write WD=32'h0C81_0400 into an empty queue -> next cycle INS=32'h0C81_0400 and COUNT=1. INS_DONE pulse -> next cycle INS=32'h0000_1C00, COUNT=0.
- Ordering/wrap: write 12 distinct words A0..A11, popping between writes so COUNT never exceeds 8 -> INS presents A0..A11 strictly in order, and pointers wrap past 7 without loss.
- Full/overflow: write 9 words with no pops -> COUNT=8, FULL=1, 9th word absent, OVERFLOW=1. CLR_OVF pulse -> OVERFLOW=0. Pops return words 1..8.
- Simultaneous at full: COUNT=8, WE and INS_DONE in the same cycle -> COUNT stays 8, OVERFLOW stays 0, and the new word is delivered 8th after the pop.
- Simultaneous at one entry: COUNT=1, WE=B and INS_DONE in the same cycle -> next cycle INS=B (bypass), COUNT=1, EMPTY=0.

Source files
------------

// File: rtl/graphic_instruction_queue_if.sv
// graphic_instruction_queue_if: CPU write / graphic-unit read handshake bundle for the instruction queue
interface graphic_instruction_queue_if #(parameter int DEPTH = 8);
  localparam int AW = $clog2(DEPTH);
  logic        WE;
  logic [31:0] WD;
  logic        INS_DONE;
  logic        CLR_OVF;
  logic [31:0] INS;
  logic        EMPTY;
  logic        FULL;
  logic [AW:0] COUNT;
  logic        OVERFLOW;
  modport master (output WE, WD, INS_DONE, CLR_OVF, input INS, EMPTY, FULL, COUNT, OVERFLOW);
  modport slave  (input WE, WD, INS_DONE, CLR_OVF, output INS, EMPTY, FULL, COUNT, OVERFLOW);
endinterface

// File: rtl/graphic_instruction_queue.sv
// graphic_instruction_queue: circular queue of sprite draw instructions presented on INS (HF_CLK, RST async high, bus slave: WE/WD/INS_DONE/CLR_OVF in, INS/EMPTY/FULL/COUNT/OVERFLOW out)
module graphic_instruction_queue #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input logic                         HF_CLK,
  input logic                         RST,
  graphic_instruction_queue_if.slave  bus
);
  localparam logic [31:0] IDLE_INS = 32'h0000_1C00;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, rp_next;
  logic [AW:0] cnt, cnt_next;
  logic [31:0] ins, ins_next;
  logic ovf, push, pop;
  always_comb begin
    pop = bus.INS_DONE && cnt != '0;
    push = bus.WE && (cnt != FULL_CNT || pop);
    rp_next = rp + AW'(pop);
    cnt_next = cnt + (AW+1)'(push) - (AW+1)'(pop);
    ins_next = cnt_next == '0 ? IDLE_INS : (push && wp == rp_next) ? bus.WD : mem[rp_next];
  end
  always_ff @(posedge HF_CLK)
    if (push) mem[wp] <= bus.WD;
  always_ff @(posedge HF_CLK or posedge RST)
    if (RST) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ins <= IDLE_INS;
      ovf <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp_next;
      cnt <= cnt_next;
      ins <= ins_next;
      ovf <= (bus.WE && !push) || (ovf && !bus.CLR_OVF);
    end
  assign bus.INS = ins;
  assign bus.COUNT = cnt;
  assign bus.EMPTY = cnt == '0;
  assign bus.FULL = cnt == FULL_CNT;
  assign bus.OVERFLOW = ovf;
endmodule

// File: tb/tb_graphic_instruction_queue.sv
// tb_graphic_instruction_queue: table vectors plus scoreboard sequences for the instruction queue
module tb_graphic_instruction_queue;
  localparam int DEPTH = 8;
  localparam logic [31:0] IDLE = 32'h0000_1C00;
  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        done;
    logic [31:0] ins;
    logic [3:0]  cnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  logic [31:0] sb[$];
  logic m_ovf = 1'b0;
  vec_t tbl[9];
  graphic_instruction_queue_if #(.DEPTH(DEPTH)) bus();
  graphic_instruction_queue #(.DEPTH(DEPTH)) dut (.HF_CLK(clk), .RST(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic drive(input logic we, input logic [31:0] wd, input logic done, input logic clr);
    bit pop, push;
    pop = done && sb.size() > 0;
    push = we && (sb.size() < DEPTH || pop);
    if (we && !push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back(wd);
    bus.WE = we;
    bus.WD = wd;
    bus.INS_DONE = done;
    bus.CLR_OVF = clr;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
    bus.INS_DONE = 1'b0;
    bus.CLR_OVF = 1'b0;
  endtask
  task automatic check_model(input string tag);
    chk($sformatf("%s ins", tag), bus.INS, sb.size() > 0 ? sb[0] : IDLE);
    chk($sformatf("%s count", tag), 32'(bus.COUNT), 32'(sb.size()));
    chk($sformatf("%s empty", tag), 32'(bus.EMPTY), 32'(sb.size() == 0));
    chk($sformatf("%s full", tag), 32'(bus.FULL), 32'(sb.size() == DEPTH));
    chk($sformatf("%s overflow", tag), 32'(bus.OVERFLOW), 32'(m_ovf));
  endtask
  initial begin
    bus.WE = 1'b0;
    bus.WD = '0;
    bus.INS_DONE = 1'b0;
    bus.CLR_OVF = 1'b0;
    tbl = '{
      '{1'b1, 32'h0C81_0400, 1'b0, 32'h0C81_0400, 4'd1},
      '{1'b0, 32'h0000_0000, 1'b1, IDLE,          4'd0},
      '{1'b0, 32'h0000_0000, 1'b1, IDLE,          4'd0},
      '{1'b1, 32'h1111_1000, 1'b0, 32'h1111_1000, 4'd1},
      '{1'b1, 32'h2222_2000, 1'b1, 32'h2222_2000, 4'd1},
      '{1'b1, 32'h3333_3000, 1'b0, 32'h2222_2000, 4'd2},
      '{1'b0, 32'h0000_0000, 1'b1, 32'h3333_3000, 4'd1},
      '{1'b1, 32'hABC0_1C00, 1'b1, 32'hABC0_1C00, 4'd1},
      '{1'b0, 32'h0000_0000, 1'b1, IDLE,          4'd0}
    };
    @(posedge clk);
    #1;
    chk("reset ins", bus.INS, IDLE);
    chk("reset count", 32'(bus.COUNT), 32'd0);
    chk("reset empty", 32'(bus.EMPTY), 32'd1);
    chk("reset full", 32'(bus.FULL), 32'd0);
    chk("reset overflow", 32'(bus.OVERFLOW), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].wd, tbl[i].done, 1'b0);
      chk($sformatf("vec%0d ins", i), bus.INS, tbl[i].ins);
      chk($sformatf("vec%0d count", i), 32'(bus.COUNT), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d empty", i), 32'(bus.EMPTY), 32'(tbl[i].cnt == 0));
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'hA000_0000 | (32'(i) << 22) | (32'(i) << 13), i[0], 1'b0);
      check_model($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 16 && sb.size() > 0; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check_model($sformatf("drain%0d", i));
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h0010_0000 * 32'(i + 1), 1'b0, 1'b0);
      check_model($sformatf("fill%0d", i));
    end
    chk("full flag", 32'(bus.FULL), 32'd1);
    chk("overflow set", 32'(bus.OVERFLOW), 32'd1);
    drive(1'b1, 32'hDEAD_0000, 1'b0, 1'b1);
    check_model("clr_vs_drop");
    chk("set wins", 32'(bus.OVERFLOW), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check_model("clr");
    chk("overflow cleared", 32'(bus.OVERFLOW), 32'd0);
    drive(1'b1, 32'hC0DE_0000, 1'b1, 1'b0);
    check_model("full_pushpop");
    chk("full_pushpop count", 32'(bus.COUNT), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("last word", bus.INS, 32'hC0DE_0000);
      drive(1'b0, '0, 1'b1, 1'b0);
      check_model($sformatf("pop%0d", i));
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h5000_0000 + 32'(i), 1'b0, 1'b0);
    check_model("pre_reset");
    rst = 1'b1;
    #2;
    sb.delete();
    m_ovf = 1'b0;
    chk("async reset ins", bus.INS, IDLE);
    chk("async reset count", 32'(bus.COUNT), 32'd0);
    chk("async reset empty", 32'(bus.EMPTY), 32'd1);
    chk("async reset overflow", 32'(bus.OVERFLOW), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check_model($sformatf("idle_done%0d", i));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
